// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage
// Contents:
//   fetch_state_t  FETCH_RUN / FETCH_HALTED fetch FSM encoding
//   PC_STEP        byte distance between consecutive instruction words
package fetch_unit_pkg;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// rtl/fetch_unit_inst_fifo.sv - DEPTH-entry FIFO of {pc, inst} words for the fetch stage
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   push, push_data       write one entry at the tail
//   pop                   remove the head entry (ignored when empty)
//   flush                 discard every entry; overrides push and pop
//   head_data             head entry, zero while empty
//   count                 number of valid entries (0..DEPTH)
module fetch_unit_inst_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && !flush;

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

  // The fetch credit scheme must never push into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(do_push && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, request issue, response buffering
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   redirect, redirect_pc       taken branch: flush everything, refetch from redirect_pc
//   halt                        stop issuing requests until the next redirect
//   mem_req_valid/ready/addr    in-order instruction read requests (addr = fetch PC)
//   mem_rsp_valid/data          read data, returned in request order
//   inst_valid/ready            head-of-FIFO handshake to decode
//   inst, inst_pc               head instruction word and its PC
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc
);

  localparam int               CW   = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  fetch_state_t     state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] rsp_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credits_used;
  logic [CW-1:0]    outstanding_next;
  logic [2*WIDTH-1:0] fifo_head;
  logic             issue;
  logic             rsp_fire;
  logic             rsp_keep;
  logic             pop;

  // Every request in flight reserves a FIFO slot, so responses always fit.
  assign credits_used  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign mem_req_valid = !reset && (state == FETCH_RUN) && !halt && !redirect
                         && (credits_used < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign issue         = mem_req_valid && mem_req_ready;

  // With nothing outstanding a response is a leftover from before reset.
  assign rsp_fire = mem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_fire && (drop == '0) && !redirect;

  assign outstanding_next = outstanding + CW'(issue) - CW'(rsp_fire);

  assign pop        = inst_valid && inst_ready;
  assign inst_valid = (fifo_count != '0);
  assign inst       = fifo_head[WIDTH-1:0];
  assign inst_pc    = fifo_head[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH_RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        // Whatever is still in flight after this cycle belongs to the old path.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop     <= outstanding_next;
        state    <= halt ? FETCH_HALTED : FETCH_RUN;
      end else begin
        if (issue)                  fetch_pc <= fetch_pc + STEP;
        if (rsp_fire && drop != '0) drop     <= drop - CW'(1);
        if (rsp_keep)               rsp_pc   <= rsp_pc + STEP;
        if (halt)                   state    <= FETCH_HALTED;
      end
    end
  end

  fetch_unit_inst_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data ({rsp_pc, mem_rsp_data}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .WIDTH    (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  int          cyc;
  int          mem_lat;
  int          n_vec;
  int          n_err;
  int          first_req;
  int          first_iv;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_inst.delete();
    first_req = -1;
    first_iv  = -1;
  endtask

  task automatic drive_rsp();
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pend_addr[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  endtask

  // Observe at negedge, then advance to just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (mem_req_valid && mem_req_ready) begin
      req_log.push_back(mem_req_addr);
      pend_addr.push_back(mem_req_addr);
      pend_due.push_back(cyc + mem_lat);
      if (first_req < 0) first_req = cyc;
    end
    if (inst_valid && first_iv < 0) first_iv = cyc;
    if (inst_valid && inst_ready) begin
      pop_pc.push_back(inst_pc);
      pop_inst.push_back(inst);
    end
    if (mem_rsp_valid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_rsp();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    redirect      = 1'b0;
    halt          = 1'b0;
    mem_req_ready = 1'b0;
    inst_ready    = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    clear_logs();
    drive_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    mem_lat = 1;
    clear_logs();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr",  mem_req_addr,       32'h0);
    check("rst_inst_valid", 32'(inst_valid),   32'd0);
    check("rst_inst",      inst,               32'h0);
    check("rst_inst_pc",   inst_pc,            32'h0);

    // 1: streaming fetch with 1-cycle memory
    do_reset();
    mem_lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b1;
    run(8);
    check("t1_first_req",  32'(first_req),            32'd0);
    check("t1_iv_latency", 32'(first_iv - first_req), 32'd2);
    check("t1_req0", qget(req_log, 0), 32'h0);
    check("t1_req1", qget(req_log, 1), 32'h4);
    check("t1_req2", qget(req_log, 2), 32'h8);
    check("t1_req3", qget(req_log, 3), 32'hC);
    check("t1_pc0",  qget(pop_pc, 0),  32'h0);
    check("t1_pc1",  qget(pop_pc, 1),  32'h4);
    check("t1_pc2",  qget(pop_pc, 2),  32'h8);
    check("t1_inst0", qget(pop_inst, 0), 32'h1234_5678);
    check("t1_inst1", qget(pop_inst, 1), 32'h1234_567C);
    check("t1_inst2", qget(pop_inst, 2), 32'h1234_5670);

    // 2: decode stalled, credits cap issue at DEPTH
    do_reset();
    mem_lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b0;
    run(8);
    settle();
    check("t2_req_count", 32'(req_log.size()), 32'd4);
    check("t2_req_valid_full", 32'(mem_req_valid), 32'd0);
    check("t2_req3", qget(req_log, 3), 32'hC);
    check("t2_head_valid", 32'(inst_valid), 32'd1);
    check("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    run(6);
    check("t2_resume_addr", qget(req_log, 4), 32'h10);
    check("t2_pop0", qget(pop_pc, 0), 32'h0);
    check("t2_pop4", qget(pop_pc, 4), 32'h10);

    // 3: redirect with two stale requests in flight
    do_reset();
    mem_lat = 3; mem_req_ready = 1'b1; inst_ready = 1'b1;
    run(2);
    check("t3_outstanding", 32'(req_log.size()), 32'd2);
    mem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0; mem_req_ready = 1'b1;
    settle();
    check("t3_req_valid", 32'(mem_req_valid), 32'd1);
    check("t3_req_addr",  mem_req_addr,       32'h100);
    check("t3_fifo_empty", 32'(inst_valid),   32'd0);
    run(8);
    check("t3_req_after", qget(req_log, 2), 32'h100);
    check("t3_pop0_pc",   qget(pop_pc, 0),  32'h100);
    check("t3_pop0_inst", qget(pop_inst, 0), 32'h1234_5778);
    check("t3_pop1_pc",   qget(pop_pc, 1),  32'h104);

    // 4: redirect coincident with a response and a decode handshake
    do_reset();
    mem_lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b1;
    run(3);
    redirect = 1'b1; redirect_pc = 32'h200;
    settle();
    check("t4_head_valid", 32'(inst_valid), 32'd1);
    check("t4_head_pc", inst_pc, 32'h4);
    check("t4_no_issue", 32'(mem_req_valid), 32'd0);
    cycle();
    redirect = 1'b0;
    settle();
    check("t4_req_valid", 32'(mem_req_valid), 32'd1);
    check("t4_req_addr",  mem_req_addr,       32'h200);
    check("t4_fifo_empty", 32'(inst_valid),   32'd0);
    run(6);
    check("t4_pop0", qget(pop_pc, 0), 32'h0);
    check("t4_pop1", qget(pop_pc, 1), 32'h4);
    check("t4_pop2", qget(pop_pc, 2), 32'h200);
    check("t4_pop3", qget(pop_pc, 3), 32'h204);
    check("t4_inst2", qget(pop_inst, 2), 32'h1234_5478);

    // 5: halt with one request outstanding, restart by redirect
    do_reset();
    mem_lat = 3; mem_req_ready = 1'b1; inst_ready = 1'b1;
    cycle();
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    run(4);
    settle();
    check("t5_req_count", 32'(req_log.size()), 32'd1);
    check("t5_req_valid", 32'(mem_req_valid), 32'd0);
    check("t5_pop_count", 32'(pop_pc.size()), 32'd1);
    check("t5_pop0_pc",   qget(pop_pc, 0),   32'h0);
    check("t5_pop0_inst", qget(pop_inst, 0), 32'h1234_5678);
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    settle();
    check("t5_restart_valid", 32'(mem_req_valid), 32'd1);
    check("t5_restart_addr",  mem_req_addr,       32'h40);
    run(6);
    check("t5_pop1_pc", qget(pop_pc, 1), 32'h40);

    // 6: async reset with credits exhausted
    do_reset();
    mem_lat = 3; mem_req_ready = 1'b1; inst_ready = 1'b0;
    run(5);
    settle();
    check("t6_req_count", 32'(req_log.size()), 32'd4);
    check("t6_pre_valid", 32'(inst_valid), 32'd1);
    check("t6_pre_pc", inst_pc, 32'h0);
    check("t6_pre_no_issue", 32'(mem_req_valid), 32'd0);
    reset = 1'b1;
    #1;
    check("t6_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("t6_rst_req_addr",  mem_req_addr,       32'h0);
    check("t6_rst_inst_valid", 32'(inst_valid),   32'd0);
    check("t6_rst_inst",      inst,               32'h0);
    check("t6_rst_inst_pc",   inst_pc,            32'h0);
    mem_req_ready = 1'b0;
    clear_logs();
    cycle();
    reset = 1'b0;
    cycle();
    settle();
    check("t6_late_ignored", 32'(inst_valid), 32'd0);
    check("t6_req_valid", 32'(mem_req_valid), 32'd1);
    check("t6_req_addr",  mem_req_addr,       32'h0);
    mem_req_ready = 1'b1; inst_ready = 1'b1;
    run(6);
    check("t6_req0",      qget(req_log, 0),  32'h0);
    check("t6_pop0_pc",   qget(pop_pc, 0),   32'h0);
    check("t6_pop0_inst", qget(pop_inst, 0), 32'h1234_5678);
    check("t6_pop1_pc",   qget(pop_pc, 1),   32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
